data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Sequences and shares the single-port data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/debug port.
//  Translates byte addresses (base BASE_ADDR, word aligned) to word indices and inserts WAIT_CYCLES wait states per access.
//  Stalls the pipeline via cpu_ready until the access completes. Sits between the MEM stage and the data memory array.
// PARAMETERS
//  WORD_LEN     32    data width
//  ADDRESS_LEN  32    byte-address width
//  BASE_ADDR    1024  byte address of memory word 0
//  MEM_DEPTH    64    words in memory; valid range BASE_ADDR .. BASE_ADDR+4*MEM_DEPTH-1
//  WAIT_CYCLES  2     extra access cycles per transaction (0..15)
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            async active-high reset
//  cpu_r_en   in   1            MEM-stage read request (level)
//  cpu_w_en   in   1            MEM-stage write request (level); wins if both set
//  cpu_addr   in   ADDRESS_LEN  CPU byte address (ALU result)
//  cpu_wdata  in   WORD_LEN     CPU store data (Val_Rm)
//  cpu_rdata  out  WORD_LEN     registered CPU load data
//  cpu_ready  out  1            0 = freeze pipeline
//  dma_req    in   1            DMA request (level, held until dma_done)
//  dma_we     in   1            1 = DMA write
//  dma_addr   in   ADDRESS_LEN  DMA byte address
//  dma_wdata  in   WORD_LEN     DMA write data
//  dma_rdata  out  WORD_LEN     registered DMA read data
//  dma_done   out  1            one-cycle completion pulse
//  mem_r_en   out  1            memory read enable
//  mem_w_en   out  1            memory write strobe (one cycle)
//  mem_addr   out  $clog2(MEM_DEPTH)  word index = (addr-BASE_ADDR)>>2
//  mem_wdata  out  WORD_LEN     memory write data
//  mem_rdata  in   WORD_LEN     combinational memory read data
//  addr_err   out  1            one-cycle pulse: misaligned/out-of-range access
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cpu_ready=1 when no CPU request pending; wait counter 0; RR pointer = CPU.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: sample requests each edge. Winner latched with its addr/wdata/we; owner register set. None -> stay.
//  Priority: CPU always beats DMA (see CONFIGURATION).
//  Address check at grant: addr[1:0]!=0 or outside range -> skip ACCESS, go DONE, addr_err=1 in DONE, rdata=0, no mem strobe.
//  ACCESS: lasts WAIT_CYCLES+1 cycles; mem_addr/mem_wdata stable throughout; mem_r_en=1 all cycles for reads;
//   mem_w_en=1 only in last ACCESS cycle; read data captured from mem_rdata on last ACCESS edge.
//  DONE: one cycle; CPU owner -> cpu_ready=1, cpu_rdata valid and held until next CPU read; DMA owner -> dma_done=1.
//  Latency: request seen at edge 0 -> DONE in cycle WAIT_CYCLES+2; throughput one access per WAIT_CYCLES+3 cycles.
//  cpu_ready = ~(cpu_r_en|cpu_w_en) | (state==DONE & owner==CPU); combinational, no glitch across states.
//  Requester dropping request mid-transaction: transaction still completes (write still performed); done pulse still issued.
//  Simultaneous CPU+DMA in IDLE: one granted, other waits; the other is granted in the IDLE cycle after DONE.
//  Reset mid-ACCESS: immediate abort, no mem_w_en issued, no done pulse.
// CONFIGURATION
//  DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant alternates; RR pointer toggles after each completed
//   transaction to the other requester; single requester always granted.
//  Undefined: fixed CPU priority; DMA can starve under continuous CPU traffic (accepted).
// TESTING
//  CPU read addr 1028, mem[1]=0x55, WAIT_CYCLES=2 -> cpu_ready low 4 cycles, DONE in cycle 4, cpu_rdata=0x55.
//  CPU write addr 1032 data 7 -> mem_addr=2, exactly one mem_w_en pulse in last ACCESS cycle, mem_wdata=7.
//  CPU+DMA both request same edge, macro off -> CPU first, DMA granted after CPU DONE; macro on, 2nd tie -> DMA first.
//  CPU read addr 1030 (misaligned) and 1024+4*MEM_DEPTH -> addr_err pulse, no mem_r_en/mem_w_en, rdata=0, cpu_ready next cycle.
//  DMA write, rst asserted in 2nd ACCESS cycle -> mem_w_en never asserted, state IDLE, dma_done=0.
//  DMA drops dma_req in ACCESS -> write completes, dma_done pulses once, returns IDLE.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the CPU MEM stage
//   and a DMA/debug port. It turns byte addresses into word indices, adds wait
//   states to every access, and holds the pipeline on cpu_ready until the access ends.
// Ports: clk/rst (async active-high); CPU side: cpu_r_en, cpu_w_en, cpu_addr,
//   cpu_wdata, cpu_rdata, cpu_ready. DMA side: dma_req, dma_we, dma_addr,
//   dma_wdata, dma_rdata, dma_done. Memory side: mem_r_en, mem_w_en, mem_addr,
//   mem_wdata, mem_rdata. Error pulse: addr_err.
// Build option: DMEM_ARB_ROUND_ROBIN_EN. When it is defined, tied requests
//   alternate between the two requesters. When it is not defined, the CPU always wins.
module data_mem_arbiter #(
  parameter int WORD_LEN    = 32,
  parameter int ADDRESS_LEN = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_r_en,
  input  logic                         cpu_w_en,
  input  logic [ADDRESS_LEN-1:0]       cpu_addr,
  input  logic [WORD_LEN-1:0]          cpu_wdata,
  output logic [WORD_LEN-1:0]          cpu_rdata,
  output logic                         cpu_ready,
  input  logic                         dma_req,
  input  logic                         dma_we,
  input  logic [ADDRESS_LEN-1:0]       dma_addr,
  input  logic [WORD_LEN-1:0]          dma_wdata,
  output logic [WORD_LEN-1:0]          dma_rdata,
  output logic                         dma_done,
  output logic                         mem_r_en,
  output logic                         mem_w_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [WORD_LEN-1:0]          mem_wdata,
  input  logic [WORD_LEN-1:0]          mem_rdata,
  output logic                         addr_err
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [ADDRESS_LEN-1:0] LP_BASE = ADDRESS_LEN'(BASE_ADDR);
  localparam logic [ADDRESS_LEN-1:0] LP_SPAN = ADDRESS_LEN'(4 * MEM_DEPTH);
  localparam logic [3:0]             LP_WAIT = 4'(WAIT_CYCLES);

  logic [1:0]          r_state;
  logic                r_owner;
  logic                r_we;
  logic                r_err;
  logic [3:0]          r_cnt;
  logic [AW-1:0]       r_addr;
  logic [WORD_LEN-1:0] r_wdata;
  logic [WORD_LEN-1:0] r_cpu_rdata;
  logic [WORD_LEN-1:0] r_dma_rdata;

  logic                   w_cpu_req;
  logic                   w_grant_dma;
  logic [ADDRESS_LEN-1:0] w_sel_addr;
  logic [WORD_LEN-1:0]    w_sel_wdata;
  logic                   w_sel_we;
  logic [ADDRESS_LEN-1:0] w_off;
  logic                   w_bad;
  logic [AW-1:0]          w_idx;
  logic                   w_last;

  assign w_cpu_req = cpu_r_en | cpu_w_en;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // r_rr = 1 means the DMA port wins the next tie. After each access, the
  // pointer moves to the requester that was not just served.
  logic r_rr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_rr <= (r_owner == OWN_CPU);
    end
  end

  assign w_grant_dma = dma_req & (~w_cpu_req | r_rr);
`else
  assign w_grant_dma = dma_req & ~w_cpu_req;
`endif

  assign w_sel_addr  = w_grant_dma ? dma_addr  : cpu_addr;
  assign w_sel_wdata = w_grant_dma ? dma_wdata : cpu_wdata;
  assign w_sel_we    = w_grant_dma ? dma_we    : cpu_w_en;

  // An address below the base wraps to a large offset, but it is also rejected
  // by the explicit lower-bound compare.
  assign w_off  = w_sel_addr - LP_BASE;
  assign w_bad  = (w_sel_addr[1:0] != 2'b00) | (w_sel_addr < LP_BASE) | (w_off >= LP_SPAN);
  assign w_idx  = w_off[AW+1:2];
  assign w_last = (r_cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cpu_req | dma_req) begin
            r_owner <= w_grant_dma;
            r_we    <= w_sel_we;
            r_err   <= w_bad;
            r_cnt   <= LP_WAIT;
            r_addr  <= w_idx;
            r_wdata <= w_sel_wdata;
            // A bad address skips the memory access and reports completion
            // with zero read data.
            r_state <= w_bad ? S_DONE : S_ACCESS;
            if (w_bad & ~w_sel_we) begin
              if (w_grant_dma) r_dma_rdata <= '0;
              else             r_cpu_rdata <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (w_last) begin
            r_state <= S_DONE;
            if (~r_we) begin
              if (r_owner == OWN_DMA) r_dma_rdata <= mem_rdata;
              else                    r_cpu_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_r_en  = (r_state == S_ACCESS) & ~r_we;
  // The write strobe fires only once, in the last wait-state cycle.
  assign mem_w_en  = (r_state == S_ACCESS) & r_we & w_last;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign cpu_ready = ~w_cpu_req | ((r_state == S_DONE) & (r_owner == OWN_CPU));
  assign dma_done  = (r_state == S_DONE) & (r_owner == OWN_DMA);
  assign addr_err  = (r_state == S_DONE) & r_err;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int W     = 2;
  localparam int BASE  = 1024;
  localparam int DEPTH = 64;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_r_en, cpu_w_en, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_ready, dma_done, mem_r_en, mem_w_en, addr_err;
  logic [5:0]  mem_addr;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .WORD_LEN(32), .ADDRESS_LEN(32), .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_r_en(cpu_r_en), .cpu_w_en(cpu_w_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  // Memory device driven by the DUT.
  logic [31:0] mem_arr [DEPTH];
  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) if (mem_w_en) mem_arr[mem_addr] <= mem_wdata;

  function automatic logic [31:0] init_val(input int i);
    return (i == 1) ? 32'h55 : (32'hA000_0000 + i);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference model: it tracks time since the grant,
  // not DUT states.
  logic [31:0] shadow [DEPTH];
  bit          m_busy = 0, m_own_dma = 0, m_we = 0, m_err = 0, m_rr = 0;
  int          m_t = 0, m_idx = 0;
  logic [31:0] m_wdata = 0, m_cpu_rd = 0, m_dma_rd = 0;
  bit          mc_req;
  longint      ma;

  function automatic int m_len();
    return m_err ? 1 : W + 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_t = 0; m_cpu_rd = 0; m_dma_rd = 0; m_rr = 0;
    end else if (m_busy) begin
      if (m_t == m_len()) begin
        m_busy = 0;
        m_rr   = !m_own_dma;
      end else begin
        if (!m_err && m_t == W + 1) begin
          if (m_we)           shadow[m_idx] = m_wdata;
          else if (m_own_dma) m_dma_rd = shadow[m_idx];
          else                m_cpu_rd = shadow[m_idx];
        end
        m_t++;
      end
    end else begin
      mc_req = cpu_r_en | cpu_w_en;
      if (mc_req || dma_req) begin
        m_own_dma = dma_req && (!mc_req || (RR && m_rr));
        ma        = m_own_dma ? longint'(dma_addr) : longint'(cpu_addr);
        m_we      = m_own_dma ? dma_we : cpu_w_en;
        m_wdata   = m_own_dma ? dma_wdata : cpu_wdata;
        m_err     = (ma % 4 != 0) || (ma < BASE) || (ma >= BASE + 4 * DEPTH);
        m_idx     = m_err ? 0 : int'((ma - BASE) / 4);
        if (m_err && !m_we) begin
          if (m_own_dma) m_dma_rd = 0; else m_cpu_rd = 0;
        end
        m_busy = 1; m_t = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  bit e_creq, e_done, e_acc;
  always @(negedge clk) begin
    e_creq = cpu_r_en | cpu_w_en;
    if (rst) begin
      chk("rst_cpu_ready", cpu_ready, !e_creq);
      chk("rst_mem_r_en", mem_r_en, 0);
      chk("rst_mem_w_en", mem_w_en, 0);
      chk("rst_dma_done", dma_done, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
    end else begin
      e_done = m_busy && (m_t == m_len());
      e_acc  = m_busy && !e_done;
      chk("cpu_ready", cpu_ready, !e_creq || (e_done && !m_own_dma));
      chk("mem_r_en", mem_r_en, e_acc && !m_we);
      chk("mem_w_en", mem_w_en, e_acc && m_we && (m_t == W + 1));
      chk("dma_done", dma_done, e_done && m_own_dma);
      chk("addr_err", addr_err, e_done && m_err);
      chk("cpu_rdata", cpu_rdata, m_cpu_rd);
      chk("dma_rdata", dma_rdata, m_dma_rd);
      if (e_acc) begin
        chk("mem_addr", mem_addr, m_idx);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // Event monitors feeding the directed checks.
  int          n_wen = 0, n_ren = 0, n_done = 0, n_err = 0;
  logic [5:0]  last_waddr = 0;
  logic [31:0] last_wdata = 0;
  byte         ord [$];
  always @(negedge clk) begin
    if (mem_w_en) begin n_wen++; last_waddr = mem_addr; last_wdata = mem_wdata; end
    if (mem_r_en) n_ren++;
    if (dma_done) begin n_done++; ord.push_back("D"); end
    if (addr_err) n_err++;
    if (!rst && cpu_ready && (cpu_r_en || cpu_w_en)) ord.push_back("C");
  end

  task automatic wait_cpu(output int low);
    bit got;
    got = 0; low = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (cpu_ready) got = 1; else low++;
    end
    chk("cpu_ready_seen", got, 1);
  endtask

  task automatic wait_dma(output int cyc);
    bit got;
    got = 0; cyc = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (dma_done) got = 1; else cyc++;
    end
    chk("dma_done_seen", got, 1);
  endtask

  task automatic cpu_access(input bit we, input logic [31:0] a, input logic [31:0] d, output int low);
    @(posedge clk); #2;
    cpu_r_en = !we; cpu_w_en = we; cpu_addr = a; cpu_wdata = d;
    wait_cpu(low);
    @(posedge clk); #2;
    cpu_r_en = 0; cpu_w_en = 0;
    @(negedge clk);
  endtask

  task automatic dma_start(input bit we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

  int low, cyc, b_wen, b_ren, b_done, b_err, b_ord;

  initial begin
    cpu_r_en = 0; cpu_w_en = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = init_val(i);
      shadow[i]  = init_val(i);
    end
    rst = 0;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("reset_cpu_ready", cpu_ready, 1);
    chk("reset_cpu_rdata", cpu_rdata, 0);
    chk("reset_mem_en", {mem_r_en, mem_w_en}, 0);

    // CPU read at byte 1028 returns word 1.
    b_ren = n_ren;
    cpu_access(0, 1028, 0, low);
    chk("rd_low_cycles", low, 4);
    chk("rd_rdata", cpu_rdata, 32'h55);
    chk("rd_ren_cycles", n_ren - b_ren, 3);

    // CPU write at byte 1032: a single strobe to word 2.
    b_wen = n_wen; b_ren = n_ren;
    cpu_access(1, 1032, 7, low);
    chk("wr_low_cycles", low, 4);
    chk("wr_pulses", n_wen - b_wen, 1);
    chk("wr_addr", last_waddr, 2);
    chk("wr_data", last_wdata, 7);
    chk("wr_mem", mem_arr[2], 7);
    chk("wr_no_ren", n_ren - b_ren, 0);

    // DMA read at byte 1044 returns word 5.
    dma_start(0, 1044, 0);
    wait_dma(cyc);
    chk("dma_rd_latency", cyc, 4);
    chk("dma_rd_data", dma_rdata, 32'hA000_0005);
    @(posedge clk); #2 dma_req = 0;
    @(negedge clk);

    // Tie: CPU is served first, then DMA right after the CPU access completes.
    b_ord = ord.size();
    @(posedge clk); #2;
    cpu_r_en = 1; cpu_addr = 1028;
    dma_req = 1; dma_we = 0; dma_addr = 1048;
    wait_cpu(low);
    chk("tie_cpu_low", low, 4);
    @(posedge clk); #2 cpu_r_en = 0;
    wait_dma(cyc);
    chk("tie_dma_wait", cyc, 4);
    chk("tie_dma_data", dma_rdata, 32'hA000_0006);
    @(posedge clk); #2 dma_req = 0;
    @(negedge clk);
    chk("tie_count", ord.size() - b_ord, 2);
    if (ord.size() >= b_ord + 2) begin
      chk("tie_first", ord[b_ord], "C");
      chk("tie_second", ord[b_ord+1], "D");
    end

    // Misaligned and out-of-range reads.
    b_err = n_err; b_ren = n_ren; b_wen = n_wen;
    cpu_access(0, 1030, 0, low);
    chk("mis_low", low, 1);
    chk("mis_rdata", cpu_rdata, 0);
    chk("mis_err", n_err - b_err, 1);
    cpu_access(0, 1028, 0, low);
    chk("reread_rdata", cpu_rdata, 32'h55);
    b_err = n_err; b_ren = n_ren;
    cpu_access(0, BASE + 4 * DEPTH, 0, low);
    chk("oor_low", low, 1);
    chk("oor_rdata", cpu_rdata, 0);
    chk("oor_err", n_err - b_err, 1);
    chk("oor_no_ren", n_ren - b_ren, 0);
    chk("err_no_wen", n_wen - b_wen, 0);

    // DMA write aborted by reset in the second wait-state cycle.
    b_wen = n_wen; b_done = n_done;
    dma_start(1, 1036, 32'hDEAD_BEEF);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1; dma_req = 0;
    @(posedge clk); #2 rst = 0;
    repeat (3) @(negedge clk);
    chk("abort_no_wen", n_wen - b_wen, 0);
    chk("abort_no_done", n_done - b_done, 0);
    chk("abort_mem", mem_arr[3], 32'hA000_0003);
    chk("abort_idle_ready", cpu_ready, 1);

    // DMA removes its request in the first wait-state cycle.
    b_wen = n_wen; b_done = n_done;
    dma_start(1, 1040, 32'h1234);
    @(posedge clk); #2 dma_req = 0;
    repeat (8) @(negedge clk);
    chk("drop_done_once", n_done - b_done, 1);
    chk("drop_wen_once", n_wen - b_wen, 1);
    chk("drop_waddr", last_waddr, 4);
    chk("drop_mem", mem_arr[4], 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
